// File: rtl/chroma_quad_serializer.sv
// rtl/chroma_quad_serializer.sv - serializes four upsampled chroma blocks in 4:2:0 quad order
//
// Captures the four 8x8 blocks produced from one subsampled chroma block in a
// single cycle, then presents them one per valid/ready handshake in the order
// TL, TR, BL, BR. Quads whose valid bit was clear at capture are skipped.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   ch            channel tag of the incoming group (1=Cb, 2=Cr)
//   valid_in      per-block valid: bit0=BR, bit1=BL, bit2=TR, bit3=TL
//   block_1_in    bottom-right block
//   block_2_in    bottom-left block
//   block_3_in    top-right block
//   block_4_in    top-left block
//   in_ready      a group can be captured this cycle
//   block_out     block currently presented
//   ch_out        channel tag of the captured group
//   quad_out      position of block_out: 0=TL, 1=TR, 2=BL, 3=BR
//   last_out      block_out is the final pending block of its group
//   valid_out     block_out is valid
//   out_ready     downstream accepts block_out
module chroma_quad_serializer #(
  parameter int PIX_W = 8,
  parameter int CH    = 2,
  parameter int CH_W  = $clog2(CH + 1)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [CH_W-1:0]                  ch,
  input  logic [3:0]                       valid_in,
  input  logic [7:0][7:0][PIX_W-1:0]       block_1_in,
  input  logic [7:0][7:0][PIX_W-1:0]       block_2_in,
  input  logic [7:0][7:0][PIX_W-1:0]       block_3_in,
  input  logic [7:0][7:0][PIX_W-1:0]       block_4_in,
  output logic                             in_ready,
  output logic [7:0][7:0][PIX_W-1:0]       block_out,
  output logic [CH_W-1:0]                  ch_out,
  output logic [1:0]                       quad_out,
  output logic                             last_out,
  output logic                             valid_out,
  input  logic                             out_ready
);

  typedef logic [7:0][7:0][PIX_W-1:0] block_t;

  // Stored blocks indexed by quad position (0=TL .. 3=BR).
  block_t          blk [4];
  logic [CH_W-1:0] ch_q;
  // Pending mask in quad order; the mask alone is the IDLE/DRAIN state.
  logic [3:0]      mask;

  logic [1:0]      quad_sel;
  logic            one_left;
  logic            capture;
  logic            fire;

  // Lowest pending quad wins, so cleared quads are skipped.
  always_comb begin
    quad_sel = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (mask[i]) quad_sel = 2'(i);
    end
  end

  assign one_left  = (mask != 4'd0) && ((mask & (mask - 4'd1)) == 4'd0);
  assign valid_out = (mask != 4'd0);
  assign last_out  = one_left;
  assign quad_out  = quad_sel;
  assign block_out = blk[quad_sel];
  assign ch_out    = ch_q;

  // Accepting on the last handshake lets back-to-back groups stream with no
  // bubble; this makes in_ready combinationally depend on out_ready.
  assign in_ready  = (mask == 4'd0) || (one_left && out_ready);
  assign capture   = (valid_in != 4'd0) && in_ready;
  assign fire      = valid_out && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask <= 4'd0;
      ch_q <= '0;
      for (int i = 0; i < 4; i++) blk[i] <= '0;
    end else if (capture) begin
      // A capture coinciding with the last handshake replaces the mask
      // rather than clearing it.
      mask   <= {valid_in[0], valid_in[1], valid_in[2], valid_in[3]};
      ch_q   <= ch;
      blk[0] <= block_4_in;
      blk[1] <= block_3_in;
      blk[2] <= block_2_in;
      blk[3] <= block_1_in;
    end else if (fire) begin
      mask <= mask & ~(4'b0001 << quad_sel);
    end
  end

endmodule

// File: tb/tb_chroma_quad_serializer.sv
// tb/tb_chroma_quad_serializer.sv - self-checking bench for chroma_quad_serializer
module tb_chroma_quad_serializer;

  typedef logic [7:0][7:0][7:0] block_t;

  typedef struct {
    block_t     data;
    logic [1:0] quad;
    logic [1:0] ch;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [1:0] ch;
  logic [3:0] valid_in;
  block_t     block_1_in, block_2_in, block_3_in, block_4_in;
  logic       in_ready;
  block_t     block_out;
  logic [1:0] ch_out;
  logic [1:0] quad_out;
  logic       last_out;
  logic       valid_out;
  logic       out_ready;

  int checks = 0;
  int failures = 0;

  exp_t q [$];

  chroma_quad_serializer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ch         (ch),
    .valid_in   (valid_in),
    .block_1_in (block_1_in),
    .block_2_in (block_2_in),
    .block_3_in (block_3_in),
    .block_4_in (block_4_in),
    .in_ready   (in_ready),
    .block_out  (block_out),
    .ch_out     (ch_out),
    .quad_out   (quad_out),
    .last_out   (last_out),
    .valid_out  (valid_out),
    .out_ready  (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic block_t fill(input logic [7:0] v);
    block_t b;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        b[r][c] = v;
    return b;
  endfunction

  function automatic block_t rnd_block();
    block_t b;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        b[r][c] = 8'($urandom);
    return b;
  endfunction

  // Reference model: a queue of the blocks still owed downstream.
  always @(negedge rst_n) q.delete();

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      int   n;
      bit   fire_m;
      bit   cap_m;
      block_t src [4];
      n      = q.size();
      fire_m = (n > 0) && out_ready;
      cap_m  = (valid_in != 4'd0) && ((n == 0) || (n == 1 && out_ready));
      src[0] = block_4_in;
      src[1] = block_3_in;
      src[2] = block_2_in;
      src[3] = block_1_in;
      if (fire_m) void'(q.pop_front());
      if (cap_m) begin
        for (int k = 0; k < 4; k++) begin
          if (valid_in[3-k]) begin
            exp_t e;
            e.data = src[k];
            e.quad = 2'(k);
            e.ch   = ch;
            q.push_back(e);
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_valid_out", 512'(valid_out), 512'(1'b0));
      chk("rst_in_ready", 512'(in_ready), 512'(1'b1));
      chk("rst_block_out", 512'(block_out), 512'(0));
      chk("rst_ch_out", 512'(ch_out), 512'(0));
      chk("rst_quad_out", 512'(quad_out), 512'(0));
      chk("rst_last_out", 512'(last_out), 512'(1'b0));
    end else if (q.size() == 0) begin
      chk("idle_valid_out", 512'(valid_out), 512'(1'b0));
      chk("idle_in_ready", 512'(in_ready), 512'(1'b1));
      chk("idle_last_out", 512'(last_out), 512'(1'b0));
    end else begin
      chk("m_valid_out", 512'(valid_out), 512'(1'b1));
      chk("m_quad_out", 512'(quad_out), 512'(q[0].quad));
      chk("m_ch_out", 512'(ch_out), 512'(q[0].ch));
      chk("m_block_out", 512'(block_out), 512'(q[0].data));
      chk("m_last_out", 512'(last_out), 512'(q.size() == 1));
      chk("m_in_ready", 512'(in_ready), 512'(q.size() == 1 && out_ready));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_const(input logic [1:0] c, input logic [3:0] vin);
    ch         = c;
    valid_in   = vin;
    block_4_in = fill(8'h10);
    block_3_in = fill(8'h20);
    block_2_in = fill(8'h30);
    block_1_in = fill(8'h40);
  endtask

  initial begin
    rst_n      = 1'b0;
    ch         = 2'd0;
    valid_in   = 4'd0;
    out_ready  = 1'b1;
    block_1_in = '0;
    block_2_in = '0;
    block_3_in = '0;
    block_4_in = '0;
    step();
    step();
    chk("reset_valid_out", 512'(valid_out), 512'(1'b0));
    chk("reset_in_ready", 512'(in_ready), 512'(1'b1));
    rst_n = 1'b1;
    step();

    // Full group, no backpressure.
    load_const(2'd1, 4'b1111);
    step();
    valid_in = 4'd0;
    for (int i = 0; i < 4; i++) begin
      chk("full_valid", 512'(valid_out), 512'(1'b1));
      chk("full_quad", 512'(quad_out), 512'(i));
      chk("full_data", 512'(block_out[3][5]), 512'(8'h10 * (i + 1)));
      chk("full_last", 512'(last_out), 512'(i == 3));
      chk("full_ch", 512'(ch_out), 512'(2'd1));
      step();
    end
    chk("full_done", 512'(valid_out), 512'(1'b0));

    // Backpressure after the first block.
    load_const(2'd1, 4'b1111);
    step();
    valid_in  = 4'd0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_data", 512'(block_out[0][0]), 512'(8'h10));
      chk("bp_hold_quad", 512'(quad_out), 512'(0));
      chk("bp_hold_last", 512'(last_out), 512'(1'b0));
      chk("bp_in_ready", 512'(in_ready), 512'(1'b0));
      step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_quad", 512'(quad_out), 512'(i));
      chk("bp_data", 512'(block_out[7][7]), 512'(8'h10 * (i + 1)));
      chk("bp_in_ready_drain", 512'(in_ready), 512'(i == 3));
      step();
    end

    // Sparse mask: TR and BR only.
    load_const(2'd2, 4'b0101);
    step();
    valid_in = 4'd0;
    chk("sparse_quad0", 512'(quad_out), 512'(1));
    chk("sparse_data0", 512'(block_out[2][1]), 512'(8'h20));
    chk("sparse_last0", 512'(last_out), 512'(1'b0));
    step();
    chk("sparse_quad1", 512'(quad_out), 512'(3));
    chk("sparse_data1", 512'(block_out[2][1]), 512'(8'h40));
    chk("sparse_last1", 512'(last_out), 512'(1'b1));
    step();
    chk("sparse_done", 512'(valid_out), 512'(1'b0));

    // Back-to-back groups.
    load_const(2'd1, 4'b1111);
    step();
    valid_in = 4'd0;
    step();
    step();
    step();
    chk("b2b_last_quad", 512'(quad_out), 512'(3));
    ch         = 2'd2;
    valid_in   = 4'b1111;
    block_1_in = fill(8'h55);
    block_2_in = fill(8'h55);
    block_3_in = fill(8'h55);
    block_4_in = fill(8'h55);
    chk("b2b_in_ready", 512'(in_ready), 512'(1'b1));
    step();
    valid_in = 4'd0;
    chk("b2b_valid", 512'(valid_out), 512'(1'b1));
    chk("b2b_quad", 512'(quad_out), 512'(0));
    chk("b2b_data", 512'(block_out[4][4]), 512'(8'h55));
    chk("b2b_ch", 512'(ch_out), 512'(2'd2));
    repeat (4) step();
    chk("b2b_done", 512'(valid_out), 512'(1'b0));

    // Mid-drain asynchronous reset.
    load_const(2'd1, 4'b1111);
    step();
    valid_in = 4'd0;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 512'(valid_out), 512'(1'b0));
    chk("arst_block", 512'(block_out), 512'(0));
    chk("arst_in_ready", 512'(in_ready), 512'(1'b1));
    step();
    rst_n = 1'b1;
    repeat (3) begin
      step();
      chk("arst_no_resume", 512'(valid_out), 512'(1'b0));
    end

    // Zero mask never captures.
    ch         = 2'd1;
    valid_in   = 4'd0;
    block_1_in = fill(8'hAA);
    block_2_in = fill(8'hBB);
    block_3_in = fill(8'hCC);
    block_4_in = fill(8'hDD);
    repeat (3) begin
      step();
      chk("zero_mask_valid", 512'(valid_out), 512'(1'b0));
    end

    // Randomized traffic checked by the model each cycle.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) valid_in = 4'd0;
      else                           valid_in = 4'($urandom);
      ch         = 2'($urandom_range(1, 2));
      block_1_in = rnd_block();
      block_2_in = rnd_block();
      block_3_in = rnd_block();
      block_4_in = rnd_block();
      out_ready  = ($urandom_range(0, 3) != 0);
      if (i == 1500) begin
        #2;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end else begin
        step();
      end
    end
    valid_in  = 4'd0;
    out_ready = 1'b1;
    repeat (6) step();
    chk("final_idle", 512'(valid_out), 512'(1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
